// File: rtl/grid_bus_arbiter_if.sv
// Player/RAM side bus of the grid arbiter: request fields from the two snake
// engines, their grant/read-valid pulses, and the registered RAM command.
interface grid_bus_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 4
);
    logic [1:0]        req;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              we0;
    logic              we1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output req, addr0, addr1, we0, we1, wdata0, wdata1,
        input  gnt, rvalid, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  req, addr0, addr1, we0, we1, wdata0, wdata1,
        output gnt, rvalid, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/grid_bus_arbiter.sv
// Shares the grid RAM between the renderer (active video) and two player engines
// (vertical-blanking window, round-robin), and generates the game tick and overrun flags.
module grid_bus_arbiter #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int TICK_FRAMES = 8,
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic [ADDR_W-1:0] pix_addr,
    grid_bus_arbiter_if.slave bus,
    output logic              game_tick,
    output logic [1:0]        overrun
);

    localparam int FC_W = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
    localparam logic [9:0]      V_FIRST   = 10'(V_ACTIVE);
    localparam logic [9:0]      V_LAST    = 10'(V_TOTAL - 2);
    localparam logic [FC_W-1:0] TICK_LAST = FC_W'(TICK_FRAMES - 1);

    typedef enum logic [1:0] {
        RENDER = 2'd0,
        UPDATE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              win_q, win_d;
    logic              win_prev_q, win_prev_d;
    logic              lp_q, lp_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              game_tick_q, game_tick_d;
    logic [1:0]        overrun_q, overrun_d;

    logic       win_rise;
    logic       win_close;
    logic [1:0] cand;
    logic       winner;

    // The line counters carry no information the arbiter needs beyond v_count.
    logic unused_h;
    assign unused_h = ^{h_count, 10'(H_ACTIVE)};

    always_comb begin
        win_d       = (v_count >= V_FIRST) && (v_count <= V_LAST);
        win_prev_d  = win_q;
        win_rise    = win_q & ~win_prev_q;
        win_close   = 1'b0;
        state_d     = state_q;
        lp_d        = lp_q;
        frame_cnt_d = frame_cnt_q;
        game_tick_d = 1'b0;
        gnt_d       = 2'b00;
        rvalid_d    = gnt_q & {2{~mem_we_q}};
        mem_addr_d  = pix_addr;
        mem_we_d    = 1'b0;
        mem_wdata_d = '0;
        cand        = 2'b00;
        winner      = 1'b0;

        case (state_q)
            RENDER: begin
                if (win_rise) begin
                    state_d = UPDATE;
                    if (frame_cnt_q == TICK_LAST) begin
                        game_tick_d = 1'b1;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            UPDATE: begin
                if (!win_q) begin
                    state_d   = DRAIN;
                    win_close = 1'b1;
                end
            end
            DRAIN:   state_d = RENDER;
            default: state_d = RENDER;
        endcase

        // Outputs are registered with the state, so arbitrate for the state being entered.
        if (state_d == UPDATE) begin
            cand = bus.req & ~gnt_q;
            if (cand == 2'b11) begin
                winner = ~lp_q;
                lp_d   = ~lp_q;
            end else begin
                winner = cand[1];
            end
            if (cand != 2'b00) begin
                gnt_d       = winner ? 2'b10 : 2'b01;
                mem_addr_d  = winner ? bus.addr1  : bus.addr0;
                mem_we_d    = winner ? bus.we1    : bus.we0;
                mem_wdata_d = winner ? bus.wdata1 : bus.wdata0;
            end
        end

        overrun_d = game_tick_d ? 2'b00 : overrun_q;
        if (win_close) begin
            overrun_d = overrun_d | bus.req;
        end
    end

    // The window flags reset high so a release mid-window does not look like a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RENDER;
            win_q       <= 1'b1;
            win_prev_q  <= 1'b1;
            lp_q        <= 1'b1;
            frame_cnt_q <= '0;
            gnt_q       <= 2'b00;
            rvalid_q    <= 2'b00;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            game_tick_q <= 1'b0;
            overrun_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            win_prev_q  <= win_prev_d;
            lp_q        <= lp_d;
            frame_cnt_q <= frame_cnt_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            game_tick_q <= game_tick_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign game_tick     = game_tick_q;
    assign overrun       = overrun_q;

endmodule

// File: doc/grid_bus_arbiter.md
# grid_bus_arbiter

Shares the single-port game-grid RAM between the pixel renderer and the two player update engines, sequenced by the VGA h/v counters. The renderer owns the RAM during active video. The two snakes' engines get round-robin access only inside the vertical-blanking update window. The block also emits the per-move game tick every TICK_FRAMES frames and flags players that fail to finish their updates inside the window. It sits between the h/v counters (same divided pixel clock) and the grid RAM.

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- V_TOTAL, 525, lines per frame (last line index V_TOTAL-1)
- TICK_FRAMES, 8, frames per game tick (≥1)
- ADDR_W, 11, grid RAM address width
- DATA_W, 4, grid cell width

- clk  in  1  pixel clock; the h/v counters run on this clock
- rst_n  in  1  asynchronous, active-low reset
- h_count  in  10  horizontal counter, 0..H_TOTAL-1
- v_count  in  10  vertical counter, 0..V_TOTAL-1
- pix_addr  in  ADDR_W  renderer read address
- req  in  2  player update requests, bit i = player i
- addr0, addr1  in  ADDR_W  player address
- we0, we1  in  1  player write enable (0 = read)
- wdata0, wdata1  in  DATA_W  player write data
- gnt  out  2  one-cycle grant pulse per accepted transaction
- rvalid  out  2  one-cycle read-data-valid pulse, per player
- mem_addr  out  ADDR_W  registered RAM address
- mem_we  out  1  registered RAM write enable
- mem_wdata  out  DATA_W  registered RAM write data
- game_tick  out  1  one-cycle pulse, start of an update window every TICK_FRAMES frames
- overrun  out  2  sticky: player i still requesting when its window closed

## Operation
- The RAM is synchronous read: read data appears the cycle after mem_addr. rvalid marks that cycle; players sample the shared RAM read port directly.
- Registered window flag: win <= (v_count >= V_ACTIVE) && (v_count <= V_TOTAL-2). The last frame line (V_TOTAL-1) is reserved so the renderer can prefetch line 0.
- State machine:
  - RENDER: the window is closed.
  - UPDATE: the window is open.
  - DRAIN: one cycle after UPDATE closes, so the final rvalid can issue.
- Transitions:
  - RENDER→UPDATE when win rises.
  - UPDATE→DRAIN when win falls.
  - DRAIN→RENDER unconditionally.
- RENDER/DRAIN: every cycle mem_addr <= pix_addr, mem_we <= 0, mem_wdata <= 0. No grants.
- UPDATE, per cycle:
  - Candidates: bits with req[i]=1, excluding the player granted in the previous cycle.
  - If both are candidates, grant the one not pointed to by last-grant pointer lp, then lp <= winner.
  - Winner i: gnt[i] <= 1; mem_addr/mem_we/mem_wdata <= player i fields.
  - No winner: mem_addr <= pix_addr, mem_we <= 0.
- Grant rules:
  - No player is granted on two consecutive cycles.
  - A lone requester therefore gets at most every other cycle.
  - Contending requesters alternate every cycle.
- Handshake:
  - A player holds req and fields stable until it sees gnt.
  - In the gnt cycle it may present the next transaction or drop req.
  - rvalid[i] asserts exactly one cycle after gnt[i] when the granted we was 0.
- Tick:
  - frame_cnt (width ⌈log2 TICK_FRAMES⌉) increments on each RENDER→UPDATE transition.
  - When frame_cnt == TICK_FRAMES-1 at that transition: game_tick pulses in the first UPDATE cycle and frame_cnt <= 0.
- Overrun:
  - On UPDATE→DRAIN, overrun[i] <= overrun[i] | req[i].
  - Both bits clear on game_tick. If clear and set coincide, the set wins.
- Reset mid-frame: everything returns to reset values immediately. The state re-enters UPDATE only on the next rising win, so a partially elapsed window is never granted.

## Timing
- Reset values: gnt=0, rvalid=0, mem_addr=0, mem_we=0, mem_wdata=0, game_tick=0, overrun=0. Internal: state=RENDER, lp=1 (player 0 wins the first contention), frame_cnt=0.
- win lags the counters by 1 cycle. First possible grant: the cycle after win rises.
- Request-to-grant latency: ≥1 cycle, registered. Grant to RAM address: same cycle as gnt. Grant to rvalid: +1 cycle.
- Renderer address latency: 1 cycle, fixed, in all states. The renderer compensates.
- gnt, rvalid and game_tick are never asserted for more than 1 consecutive cycle per bit.

## Test plan
- Reset held across v_count=480 then released at v_count=490 → no gnt until the next frame's window; all outputs 0 during reset.
- req=2'b11, both reads, held through the window → gnt alternates 01,10,01… starting with player 0. rvalid mirrors gnt delayed 1 cycle. mem_we=0 throughout.
- req[0] alone held during v_count 100 → no gnt. At window open → gnt[0] on every other cycle only; mem_addr=addr0 in each gnt cycle.
- TICK_FRAMES=3, run 7 frames → game_tick pulses at window open of frames 3 and 6 only, each 1 cycle wide.
- req[1] still high at v_count 523→524 → overrun=2'b10 from the DRAIN cycle, held until the next game_tick, then cleared.
- Player 0 write we0=1, addr0=0x123, wdata0=0xA → mem_addr=0x123, mem_we=1, mem_wdata=0xA in the gnt cycle; no rvalid.
